// File: rtl/ysyx_23060072_lsu_pkg.sv
// Shared definitions for the LSU stage: access-size codes, FSM state encodings
// and the data-memory strobe width.
package ysyx_23060072_lsu_pkg;

   localparam int MEM_STRB_W = 4;

   localparam logic [1:0] LSU_TYPE_B = 2'b00;
   localparam logic [1:0] LSU_TYPE_H = 2'b01;
   localparam logic [1:0] LSU_TYPE_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } lsu_state_e;

endpackage

// File: rtl/ysyx_23060072_lsu_align.sv
// Combinational byte-lane logic: store lane replication and strobes, load
// extraction with sign/zero extension, and misalignment detection.
module ysyx_23060072_lsu_align
   import ysyx_23060072_lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]            i_lsuType,
   input  logic [1:0]            i_offset,
   input  logic                  i_signed,
   input  logic [DATA_W-1:0]     i_storeData,
   input  logic [DATA_W-1:0]     i_loadRaw,
   output logic [DATA_W-1:0]     o_storeLane,
   output logic [MEM_STRB_W-1:0] o_strb,
   output logic [DATA_W-1:0]     o_loadData,
   output logic                  o_misalign
);

   logic [DATA_W-1:0] w_shifted;

   assign w_shifted = i_loadRaw >> {i_offset, 3'b000};

   // The reserved size code 2'b11 falls into the word branch.
   always_comb begin
      o_storeLane = i_storeData;
      o_strb      = 4'b1111;
      o_loadData  = w_shifted;
      o_misalign  = 1'b0;
      case (i_lsuType)
         LSU_TYPE_B: begin
            o_storeLane = {4{i_storeData[7:0]}};
            o_strb      = 4'b0001 << i_offset;
            o_loadData  = {{(DATA_W-8){i_signed & w_shifted[7]}}, w_shifted[7:0]};
         end
         LSU_TYPE_H: begin
            o_storeLane = {2{i_storeData[15:0]}};
            o_strb      = 4'b0011 << i_offset;
            o_loadData  = {{(DATA_W-16){i_signed & w_shifted[15]}}, w_shifted[15:0]};
            o_misalign  = i_offset[0];
         end
         default: begin
            o_misalign = |i_offset;
         end
      endcase
   end

endmodule

// File: rtl/ysyx_23060072_lsu_stage.sv
// Memory-access pipeline stage: one load/store per instruction over a
// valid/ready data port, stalling upstream stages while the access is in flight.
module ysyx_23060072_lsu_stage
   import ysyx_23060072_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_flag_i,
   input  logic [1:0]            LSU_type_i,
   input  logic                  store_flag_i,
   input  logic                  load_flag_i,
   input  logic                  LSU_signed_i,
   input  logic [4:0]            wb_addr_i,
   input  logic [DATA_W-1:0]     operand_a_i,
   input  logic [DATA_W-1:0]     operand_b_i,
   input  logic [DATA_W-1:0]     operand_imm_i,
   input  logic [DATA_W-1:0]     wb_data_ex_i,
   input  logic                  lsu_hold_flag_i,
   output logic                  lsu_hold_flag_o,
   output logic                  lsu_misalign_o,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic                  mem_req_we_o,
   output logic [ADDR_W-1:0]     mem_req_addr_o,
   output logic [DATA_W-1:0]     mem_req_wdata_o,
   output logic [MEM_STRB_W-1:0] mem_req_wstrb_o,
   input  logic                  mem_rsp_valid_i,
   input  logic [DATA_W-1:0]     mem_rsp_rdata_i,
   output logic                  wb_flag_o,
   output logic [4:0]            wb_addr_o,
   output logic [DATA_W-1:0]     wb_data_o
);

   lsu_state_e              r_state;
   lsu_state_e              w_nextState;
   logic [DATA_W-1:0]       r_rdataBuf;
   logic                    r_wbFlag;
   logic [4:0]              r_wbAddr;
   logic [DATA_W-1:0]       r_wbData;
   logic                    r_misalign;

   logic [DATA_W-1:0]       w_ea;
   logic                    w_memOp;
   logic                    w_misalign;
   logic                    w_inReq;
   logic [DATA_W-1:0]       w_storeLane;
   logic [MEM_STRB_W-1:0]   w_strb;
   logic [DATA_W-1:0]       w_loadData;
   logic                    w_capture;
   logic                    w_capFlag;
   logic [DATA_W-1:0]       w_capData;
   logic                    w_misPulse;

   assign w_ea    = operand_a_i + operand_imm_i;
   assign w_memOp = load_flag_i | store_flag_i;
   assign w_inReq = (r_state == ST_REQ);

   ysyx_23060072_lsu_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .i_lsuType   (LSU_type_i),
      .i_offset    (w_ea[1:0]),
      .i_signed    (LSU_signed_i),
      .i_storeData (operand_b_i),
      .i_loadRaw   (r_rdataBuf),
      .o_storeLane (w_storeLane),
      .o_strb      (w_strb),
      .o_loadData  (w_loadData),
      .o_misalign  (w_misalign)
   );

   // Upstream operands are frozen while hold is high, so the request payload
   // can be driven straight from them and stays stable until the handshake.
   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      w_capFlag   = 1'b0;
      w_capData   = wb_data_ex_i;
      w_misPulse  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_memOp) begin
               if (!w_misalign) begin
                  w_nextState = ST_REQ;
               end else if (!lsu_hold_flag_i) begin
                  w_capture  = 1'b1;
                  w_misPulse = 1'b1;
               end
            end else if (!lsu_hold_flag_i) begin
               w_capture = 1'b1;
               w_capFlag = wb_flag_i;
            end
         end
         ST_REQ: begin
            if (mem_req_ready_i) w_nextState = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rsp_valid_i) w_nextState = ST_DONE;
         end
         ST_DONE: begin
            if (!lsu_hold_flag_i) begin
               w_nextState = ST_IDLE;
               w_capture   = 1'b1;
               w_capFlag   = load_flag_i & wb_flag_i;
               if (load_flag_i) w_capData = w_loadData;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rdataBuf <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_WAIT && mem_rsp_valid_i && load_flag_i) r_rdataBuf <= mem_rsp_rdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbFlag   <= 1'b0;
         r_wbAddr   <= '0;
         r_wbData   <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_misPulse;
         if (w_capture) begin
            r_wbFlag <= w_capFlag;
            r_wbAddr <= wb_addr_i;
            r_wbData <= w_capData;
         end
      end
   end

   // Hold is qualified with reset so the stall releases the moment reset hits.
   assign lsu_hold_flag_o = !rst & (((r_state == ST_IDLE) & w_memOp & !w_misalign) |
                                    (r_state == ST_REQ) | (r_state == ST_WAIT));
   assign lsu_misalign_o  = r_misalign;
   assign mem_req_valid_o = w_inReq;
   assign mem_req_we_o    = w_inReq & store_flag_i;
   assign mem_req_addr_o  = w_inReq ? {w_ea[ADDR_W-1:2], 2'b00} : '0;
   assign mem_req_wdata_o = (w_inReq & store_flag_i) ? w_storeLane : '0;
   assign mem_req_wstrb_o = (w_inReq & store_flag_i) ? w_strb : '0;
   assign wb_flag_o       = r_wbFlag;
   assign wb_addr_o       = r_wbAddr;
   assign wb_data_o       = r_wbData;

endmodule

// File: tb/tb_ysyx_23060072_lsu_stage.sv
// Self-checking bench for ysyx_23060072_lsu_stage: a table of directed
// accesses plus hand-written backpressure, hold, misalign and reset sequences.
module tb_ysyx_23060072_lsu_stage;

   logic        clk;
   logic        rst;
   logic        wb_flag_i;
   logic [1:0]  LSU_type_i;
   logic        store_flag_i;
   logic        load_flag_i;
   logic        LSU_signed_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] operand_a_i;
   logic [31:0] operand_b_i;
   logic [31:0] operand_imm_i;
   logic [31:0] wb_data_ex_i;
   logic        lsu_hold_flag_i;
   logic        lsu_hold_flag_o;
   logic        lsu_misalign_o;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic        mem_req_we_o;
   logic [31:0] mem_req_addr_o;
   logic [31:0] mem_req_wdata_o;
   logic [3:0]  mem_req_wstrb_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_rdata_i;
   logic        wb_flag_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;

   int checks;
   int failures;

   typedef struct {
      logic        wbFlag;
      logic [1:0]  lsuType;
      logic        isStore;
      logic        isLoad;
      logic        sgn;
      logic [4:0]  wbAddr;
      logic [31:0] opA;
      logic [31:0] opB;
      logic [31:0] imm;
      logic [31:0] exData;
      logic [31:0] rdata;
      logic        expMem;
      logic [31:0] expMemAddr;
      logic        expWe;
      logic [31:0] expWdata;
      logic [3:0]  expStrb;
      logic        expMisalign;
      logic        expFlag;
      logic        chkData;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[12];

   ysyx_23060072_lsu_stage dut (
      .clk             (clk),
      .rst             (rst),
      .wb_flag_i       (wb_flag_i),
      .LSU_type_i      (LSU_type_i),
      .store_flag_i    (store_flag_i),
      .load_flag_i     (load_flag_i),
      .LSU_signed_i    (LSU_signed_i),
      .wb_addr_i       (wb_addr_i),
      .operand_a_i     (operand_a_i),
      .operand_b_i     (operand_b_i),
      .operand_imm_i   (operand_imm_i),
      .wb_data_ex_i    (wb_data_ex_i),
      .lsu_hold_flag_i (lsu_hold_flag_i),
      .lsu_hold_flag_o (lsu_hold_flag_o),
      .lsu_misalign_o  (lsu_misalign_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_we_o    (mem_req_we_o),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_wdata_o (mem_req_wdata_o),
      .mem_req_wstrb_o (mem_req_wstrb_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_rdata_i (mem_rsp_rdata_i),
      .wb_flag_o       (wb_flag_o),
      .wb_addr_o       (wb_addr_o),
      .wb_data_o       (wb_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every check happens 1 time unit after a rising edge (or later).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic driveIdle();
      wb_flag_i     = 1'b0;
      LSU_type_i    = 2'b00;
      store_flag_i  = 1'b0;
      load_flag_i   = 1'b0;
      LSU_signed_i  = 1'b0;
      wb_addr_i     = 5'd0;
      operand_a_i   = 32'h0;
      operand_b_i   = 32'h0;
      operand_imm_i = 32'h0;
      wb_data_ex_i  = 32'h0;
   endtask

   task automatic driveVec(input vec_t v);
      wb_flag_i     = v.wbFlag;
      LSU_type_i    = v.lsuType;
      store_flag_i  = v.isStore;
      load_flag_i   = v.isLoad;
      LSU_signed_i  = v.sgn;
      wb_addr_i     = v.wbAddr;
      operand_a_i   = v.opA;
      operand_b_i   = v.opB;
      operand_imm_i = v.imm;
      wb_data_ex_i  = v.exData;
   endtask

   // Runs one vector; memory accepts at once and responds one cycle later,
   // so hold must read 1,1,1,0 across IDLE/REQ/WAIT/DONE.
   task automatic applyStimulus(input vec_t v, input int idx);
      driveVec(v);
      mem_req_ready_i = 1'b1;
      #1;
      checkOutput($sformatf("v%0d_hold_idle", idx), {31'b0, lsu_hold_flag_o}, {31'b0, v.expMem});
      checkOutput($sformatf("v%0d_valid_idle", idx), {31'b0, mem_req_valid_o}, 32'h0);
      if (v.expMem) begin
         tick();
         checkOutput($sformatf("v%0d_valid_req", idx), {31'b0, mem_req_valid_o}, 32'h1);
         checkOutput($sformatf("v%0d_addr", idx), mem_req_addr_o, v.expMemAddr);
         checkOutput($sformatf("v%0d_we", idx), {31'b0, mem_req_we_o}, {31'b0, v.expWe});
         checkOutput($sformatf("v%0d_wdata", idx), mem_req_wdata_o, v.expWdata);
         checkOutput($sformatf("v%0d_wstrb", idx), {28'b0, mem_req_wstrb_o}, {28'b0, v.expStrb});
         checkOutput($sformatf("v%0d_hold_req", idx), {31'b0, lsu_hold_flag_o}, 32'h1);
         tick();
         mem_req_ready_i = 1'b0;
         mem_rsp_valid_i = 1'b1;
         mem_rsp_rdata_i = v.rdata;
         checkOutput($sformatf("v%0d_valid_wait", idx), {31'b0, mem_req_valid_o}, 32'h0);
         checkOutput($sformatf("v%0d_hold_wait", idx), {31'b0, lsu_hold_flag_o}, 32'h1);
         tick();
         mem_rsp_valid_i = 1'b0;
         mem_rsp_rdata_i = 32'h5A5A_0F0F;
         checkOutput($sformatf("v%0d_hold_done", idx), {31'b0, lsu_hold_flag_o}, 32'h0);
      end
      tick();
      checkOutput($sformatf("v%0d_wb_flag", idx), {31'b0, wb_flag_o}, {31'b0, v.expFlag});
      checkOutput($sformatf("v%0d_wb_addr", idx), {27'b0, wb_addr_o}, {27'b0, v.wbAddr});
      if (v.chkData) checkOutput($sformatf("v%0d_wb_data", idx), wb_data_o, v.expData);
      checkOutput($sformatf("v%0d_misalign", idx), {31'b0, lsu_misalign_o}, {31'b0, v.expMisalign});
      driveIdle();
      mem_req_ready_i = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd5,  32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h1234_5678};
      vecs[1]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 5'd7,  32'h100, 32'h0, 32'h3, 32'h0, 32'h80AA_BBCC,
                   1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 5'd8,  32'h200, 32'h0000_BEEF, 32'h2, 32'h0, 32'h0,
                   1'b1, 32'h200, 1'b1, 32'hBEEF_BEEF, 4'hC, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 5'd4,  32'h100, 32'h0, 32'h2, 32'h99, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 5'd10, 32'h300, 32'h0, 32'h2, 32'h0, 32'h8001_7FFF,
                   1'b1, 32'h300, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h0000_8001};
      vecs[5]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 5'd11, 32'h2FF, 32'h0, 32'h1, 32'h0, 32'h1234_F00D,
                   1'b1, 32'h300, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_F00D};
      vecs[6]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 5'd12, 32'hFFFF_FFFC, 32'h0, 32'h8, 32'h0, 32'hDEAD_BEEF,
                   1'b1, 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
      vecs[7]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd13, 32'h10, 32'h1234_56A5, 32'h1, 32'h0, 32'h0,
                   1'b1, 32'h10, 1'b1, 32'hA5A5_A5A5, 4'h2, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 5'd14, 32'h20, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h20, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd15, 32'h41, 32'h0, 32'h0, 32'h0, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[10] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'd16, 32'h50, 32'h0, 32'h1, 32'h0, 32'h0000_F300,
                   1'b1, 32'h50, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h0000_00F3};
      vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd31, 32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0,
                   1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5};

      rst             = 1'b1;
      lsu_hold_flag_i = 1'b0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_rdata_i = 32'h0;
      driveIdle();
      tick();
      tick();
      checkOutput("reset_valid", {31'b0, mem_req_valid_o}, 32'h0);
      checkOutput("reset_hold", {31'b0, lsu_hold_flag_o}, 32'h0);
      checkOutput("reset_wb_flag", {31'b0, wb_flag_o}, 32'h0);
      checkOutput("reset_wb_data", wb_data_o, 32'h0);
      checkOutput("reset_misalign", {31'b0, lsu_misalign_o}, 32'h0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

      // Misalign must be a single-cycle pulse.
      driveVec(vecs[3]);
      tick();
      checkOutput("mis_pulse_hi", {31'b0, lsu_misalign_o}, 32'h1);
      driveIdle();
      tick();
      checkOutput("mis_pulse_lo", {31'b0, lsu_misalign_o}, 32'h0);

      // Backpressure: ready low for 5 cycles, payload must not move.
      wb_flag_i     = 1'b0;
      LSU_type_i    = 2'b10;
      store_flag_i  = 1'b1;
      wb_addr_i     = 5'd2;
      operand_a_i   = 32'h80;
      operand_b_i   = 32'h0102_0304;
      operand_imm_i = 32'h0;
      #1;
      checkOutput("bp_hold_idle", {31'b0, lsu_hold_flag_o}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("bp_valid_%0d", i), {31'b0, mem_req_valid_o}, 32'h1);
         checkOutput($sformatf("bp_addr_%0d", i), mem_req_addr_o, 32'h80);
         checkOutput($sformatf("bp_wdata_%0d", i), mem_req_wdata_o, 32'h0102_0304);
         checkOutput($sformatf("bp_wstrb_%0d", i), {28'b0, mem_req_wstrb_o}, 32'hF);
         checkOutput($sformatf("bp_hold_%0d", i), {31'b0, lsu_hold_flag_o}, 32'h1);
      end
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      checkOutput("bp_valid_wait", {31'b0, mem_req_valid_o}, 32'h0);
      checkOutput("bp_hold_wait", {31'b0, lsu_hold_flag_o}, 32'h1);
      tick();
      mem_rsp_valid_i = 1'b0;
      checkOutput("bp_hold_done", {31'b0, lsu_hold_flag_o}, 32'h0);
      tick();
      checkOutput("bp_wb_flag", {31'b0, wb_flag_o}, 32'h0);
      driveIdle();

      // Controller hold freezes the output register, both in IDLE and DONE.
      wb_flag_i    = 1'b1;
      wb_addr_i    = 5'd12;
      wb_data_ex_i = 32'h0BAD_F00D;
      tick();
      lsu_hold_flag_i = 1'b1;
      wb_addr_i       = 5'd13;
      wb_data_ex_i    = 32'h1111_1111;
      tick();
      checkOutput("hold_idle_addr", {27'b0, wb_addr_o}, 32'd12);
      checkOutput("hold_idle_data", wb_data_o, 32'h0BAD_F00D);
      lsu_hold_flag_i = 1'b0;
      tick();
      checkOutput("hold_rel_data", wb_data_o, 32'h1111_1111);
      wb_addr_i     = 5'd9;
      LSU_type_i    = 2'b10;
      load_flag_i   = 1'b1;
      operand_imm_i = 32'h40;
      mem_req_ready_i = 1'b1;
      tick();
      tick();
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'h55AA_55AA;
      tick();
      mem_rsp_valid_i = 1'b0;
      lsu_hold_flag_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput($sformatf("hold_done_data_%0d", i), wb_data_o, 32'h1111_1111);
         checkOutput($sformatf("hold_done_hold_%0d", i), {31'b0, lsu_hold_flag_o}, 32'h0);
      end
      lsu_hold_flag_i = 1'b0;
      tick();
      checkOutput("hold_done_rel_data", wb_data_o, 32'h55AA_55AA);
      checkOutput("hold_done_rel_addr", {27'b0, wb_addr_o}, 32'd9);
      driveIdle();

      // Reset while waiting for a response; a late response must be ignored.
      wb_flag_i   = 1'b1;
      wb_addr_i   = 5'd3;
      LSU_type_i  = 2'b10;
      load_flag_i = 1'b1;
      operand_a_i = 32'h60;
      mem_req_ready_i = 1'b1;
      tick();
      tick();
      mem_req_ready_i = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rst_wait_valid", {31'b0, mem_req_valid_o}, 32'h0);
      checkOutput("rst_wait_hold", {31'b0, lsu_hold_flag_o}, 32'h0);
      checkOutput("rst_wait_wb_addr", {27'b0, wb_addr_o}, 32'h0);
      checkOutput("rst_wait_wb_data", wb_data_o, 32'h0);
      driveIdle();
      tick();
      rst = 1'b0;
      tick();
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'hBAD0_BAD0;
      tick();
      mem_rsp_valid_i = 1'b0;
      tick();
      checkOutput("late_rsp_valid", {31'b0, mem_req_valid_o}, 32'h0);
      checkOutput("late_rsp_hold", {31'b0, lsu_hold_flag_o}, 32'h0);
      checkOutput("late_rsp_wb_flag", {31'b0, wb_flag_o}, 32'h0);
      checkOutput("late_rsp_wb_data", wb_data_o, 32'h0);
      applyStimulus(vecs[0], 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_23060072_lsu_stage.md
Name: ysyx_23060072_lsu_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its registered outputs (LSU controls, operands, wb address/data).
- Computes the effective address and issues one load/store per instruction on a simple valid/ready data-memory port.
- Aligns and extends load data; stalls the pipeline through a hold flag to the controller.
- Registers the write-back triple (flag, address, data) for the WB stage.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data width; fixed at 32 for RV32E.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- wb_flag_i  in  1  instruction writes rd.
- LSU_type_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- store_flag_i  in  1  store instruction.
- load_flag_i  in  1  load instruction.
- LSU_signed_i  in  1  sign-extend load result.
- wb_addr_i  in  5  rd index.
- operand_a_i  in  32  base register value.
- operand_b_i  in  32  store data register value.
- operand_imm_i  in  32  offset.
- wb_data_ex_i  in  32  execute-stage result.
- lsu_hold_flag_i  in  1  controller freezes this stage's output register.
- lsu_hold_flag_o  out  1  stage busy; controller must hold ex and earlier stages.
- lsu_misalign_o  out  1  one-cycle pulse on a misaligned access.
- mem_req_valid_o  out  1  request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_we_o  out  1  1 = write.
- mem_req_addr_o  out  32  word-aligned address: ea[31:2], 2'b00.
- mem_req_wdata_o  out  32  store data shifted to byte lane.
- mem_req_wstrb_o  out  4  byte strobes.
- mem_rsp_valid_i  in  1  response (read data or write ack) valid.
- mem_rsp_rdata_i  in  32  read data.
- wb_flag_o  out  1  registered to WB.
- wb_addr_o  out  5  registered to WB.
- wb_data_o  out  32  registered to WB.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-transaction: mem_req_valid_o drops immediately and any outstanding response is discarded.
- Effective address: ea = operand_a_i + operand_imm_i, modulo 2^32.
- mem_op = load_flag_i | store_flag_i.
- Misalignment: half with ea[0]=1, or word with ea[1:0]!=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, mem_op and aligned: go to REQ. lsu_hold_flag_o is asserted combinationally in this cycle.
- IDLE, mem_op and misaligned: no bus transaction; pulse lsu_misalign_o; output register captures wb_flag=0; stay IDLE.
- IDLE, no mem_op: pass-through. When !lsu_hold_flag_i, register wb_flag_i/wb_addr_i/wb_data_ex_i; latency 1 cycle.
- REQ: mem_req_valid_o=1 with addr/we/wdata/wstrb held stable until the handshake.
- REQ, mem_req_valid_o & mem_req_ready_i: go to WAIT.
- REQ, no ready: stay in REQ (no timeout).
- WAIT: on mem_rsp_valid_i, latch rdata (load) into an internal buffer and go to DONE. A response arriving in the same cycle as REQ acceptance is not possible; memory returns responses at least 1 cycle after acceptance.
- DONE: lsu_hold_flag_o=0.
- DONE, !lsu_hold_flag_i: output register captures the result; go to IDLE.
  - Load: wb_data_o = extended load data, wb_flag_o = wb_flag_i.
  - Store: wb_flag_o = 0.
- DONE, lsu_hold_flag_i: stay in DONE.
- lsu_hold_flag_o = (IDLE & mem_op & aligned) | REQ | WAIT. Inputs stay stable while it is high because ex_stage is held.
- Minimum memory-op occupancy is 4 cycles (IDLE, REQ, WAIT, DONE) with ready=1 and a 1-cycle response.
- Store lanes:
  - byte: wdata = {4{b[7:0]}}, wstrb = 0001 << ea[1:0].
  - half: wdata = {2{b[15:0]}}, wstrb = 0011 << ea[1:0].
  - word: wdata = b, wstrb = 1111.
- Load extract: shift rdata right by 8*ea[1:0], then zero- or sign-extend from bit 7 (byte) or bit 15 (half) per LSU_signed_i.
- Output register while lsu_hold_flag_i=1: holds its value in every state.

Decomposition:
- Shared define file additions: LSU_TYPE_B/H/W codes, FSM state encodings, MEM_STRB_W.
- One sub-module: ysyx_23060072_lsu_align.
  - Combinational store lane/strobe generation.
  - Load extraction and extension.
  - Misalign detect.
- FSM and pipeline register stay in the top module.

Test Plan:
- Pass-through: no mem_op, wb_flag=1, addr=5, data=0x1234_5678 -> next cycle wb_flag_o=1, wb_addr_o=5, wb_data_o=0x1234_5678; hold_o never high.
- Signed byte load: a=0x100, imm=3, type=00, signed=1, rdata=0x80AA_BBCC -> req addr 0x100, we=0; wb_data_o=0xFFFF_FF80 after DONE; hold_o high exactly 3 cycles.
- Half store: a=0x200, imm=2, b=0x0000_BEEF, type=01 -> wstrb=1100, wdata=0xBEEF_BEEF, addr 0x200; wb_flag_o=0.
- Backpressure: mem_req_ready_i low 5 cycles -> valid and payload stable throughout; hold_o high until DONE.
- Misaligned word load: ea=0x102 -> no mem_req_valid_o; lsu_misalign_o pulses 1 cycle; wb_flag_o=0.
- Reset in WAIT: assert rst -> mem_req_valid_o=0, hold_o=0, all outputs 0 immediately; a late mem_rsp_valid_i after release is ignored.
